mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: memory read latency in cycles, legal range 1..4.
REQ-002 SHALL have parameter STARVE_MAX, default 4: fetch starvation limit in cycles, 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports f_req in 1, f_addr in 16 and f_gnt out 1, the fetch requester.
REQ-006 SHALL have ports f_rvalid out 1 and f_rdata out 16, the fetch response.
REQ-007 SHALL have ports l_req in 1, l_addr in 16 and l_gnt out 1, the load requester.
REQ-008 SHALL have ports l_rvalid out 1 and l_rdata out 16, the load response.
REQ-009 SHALL have ports s_req in 1, s_addr in 16, s_data in 16 and s_gnt out 1, the store requester.
REQ-010 SHALL have port flush, input, 1: redirect (jump, taken jeq, self-modifying store); kills fetch traffic.
REQ-011 SHALL have ports m_ren out 1, m_wen out 1, m_addr out 16 and m_wdata out 16: command to the single-port memory.
REQ-012 SHALL have port m_rdata, input, 16: read data returned RD_LAT cycles after m_ren.

Function
REQ-013 SHALL grant at most one requester per cycle; grants and m_* are combinational from requests and state.
REQ-014 SHALL use default priority store > load > fetch.
REQ-015 SHALL, on a store grant, assert m_wen=1 and m_ren=0, with m_addr=s_addr and m_wdata=s_data.
REQ-016 SHALL, on a read grant, assert m_ren=1 and m_wen=0, with m_addr = the granted address.
REQ-017 SHALL drive m_addr, m_wdata, m_ren and m_wen to 0 when nothing is granted.
REQ-018 SHALL hold an RD_LAT-deep tag shift register of {valid, id}, with id in {FETCH, LOAD}, and push one entry every cycle.
REQ-019 SHALL assert x_rvalid with x_rdata=m_rdata exactly RD_LAT cycles after x_gnt; otherwise x_rdata=0.
REQ-020 SHALL keep responses in grant order; an ungranted requester retries, and no request is queued internally.
REQ-021 SHALL, when flush=1, clear every in-flight FETCH tag and suppress f_gnt in that cycle.
REQ-022 SHALL, during flush, leave load and store grants and LOAD tags unaffected.
REQ-023 SHALL serialize store-then-read to the same address through port order; memory returns the new value and no forwarding is done.

Reset
REQ-024 SHALL, when rst=1, clear all tags, clear the starvation counter, return the FSM to NORMAL, and force all grants, rvalids, rdata and m_* to 0.
REQ-025 SHALL drop reads in flight at reset, with no response after rst deasserts.
REQ-026 SHALL accept a new grant in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when macro MEM_ARB_FETCH_STARVE_EN is defined, include a 2-state FSM with states NORMAL and FETCH_BOOST.
REQ-028 SHALL, with that macro defined, drive a 4-bit counter that increments on f_req && !f_gnt && !flush and clears on f_gnt or flush.
REQ-029 SHALL, with that macro defined, go NORMAL -> FETCH_BOOST when the counter reaches STARVE_MAX.
REQ-030 SHALL, in FETCH_BOOST, rank fetch highest and return to NORMAL on f_gnt or flush.
REQ-031 SHALL, when MEM_ARB_FETCH_STARVE_EN is undefined, use strict priority with no counter or FSM logic.

Structure
REQ-032 SHALL place the requester-id enum (FETCH, LOAD), the FSM state enum and the ADDR_W=16 and DATA_W=16 constants in shared package mem_arb_pkg.
REQ-033 SHALL implement the tag pipeline as sub-module mem_arb_tag_pipe (parameter RD_LAT) with ports clk, rst, push_valid, push_id, kill_fetch, pop_valid and pop_id.

Verification
REQ-034 SHALL cover: f_req alone, f_addr=0x0010, RD_LAT=2 -> f_gnt in cycle 0 and f_rvalid in cycle 2 with f_rdata=mem[0x0010].
REQ-035 SHALL cover: f_req, l_req and s_req all set, s_addr=0x0020, s_data=0xBEEF -> s_gnt only and m_wen=1; next cycle l_gnt; then f_gnt.
REQ-036 SHALL cover: store 0x1234 to 0x0030, then load 0x0030 -> l_rdata=0x1234.
REQ-037 SHALL cover: fetch granted in cycle 0, flush in cycle 1 -> no f_rvalid in cycle 2; l_rvalid for a load granted in cycle 1 is still delivered.
REQ-038 SHALL cover, with MEM_ARB_FETCH_STARVE_EN: l_req held and f_req held -> f_gnt in cycle STARVE_MAX (4), then load resumes. Without the macro -> f_gnt is never asserted while l_req=1.
REQ-039 SHALL cover: rst asserted one cycle after a load grant -> no l_rvalid; all outputs 0 during reset.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory port arbiter and its tag pipeline.
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic {
    FETCH = 1'b0,
    LOAD  = 1'b1
  } reqId_t;

  typedef enum logic {
    NORMAL      = 1'b0,
    FETCH_BOOST = 1'b1
  } arbState_t;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Read-tag delay line: one {valid, id} entry enters per cycle and leaves RD_LAT cycles later,
// aligned with the memory read data. kill_fetch drops every fetch tag still in flight.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_valid,
  input  reqId_t push_id,
  input  logic   kill_fetch,
  output logic   pop_valid,
  output reqId_t pop_id
);

  logic [RD_LAT-1:0] tagValid;
  logic [RD_LAT-1:0] tagIsLoad;
  logic [RD_LAT-1:0] validIn;
  logic [RD_LAT-1:0] isLoadIn;

  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : gStage
      if (gi == 0) begin : gHead
        assign validIn[gi]  = push_valid;
        assign isLoadIn[gi] = (push_id == LOAD);
      end else begin : gBody
        assign validIn[gi]  = tagValid[gi-1] && !(kill_fetch && !tagIsLoad[gi-1]);
        assign isLoadIn[gi] = tagIsLoad[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      tagValid  <= '0;
      tagIsLoad <= '0;
    end else begin
      tagValid  <= validIn;
      tagIsLoad <= isLoadIn;
    end
  end

  // A fetch tag leaving in the flush cycle belongs to the abandoned stream as well.
  assign pop_valid = tagValid[RD_LAT-1] && !(kill_fetch && !tagIsLoad[RD_LAT-1]);
  assign pop_id    = tagIsLoad[RD_LAT-1] ? LOAD : FETCH;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, load and store; priority store > load > fetch.
// Define MEM_ARB_FETCH_STARVE_EN to add the fetch-starvation boost FSM.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic [ADDR_W-1:0] l_addr,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              s_req,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_gnt,
  input  logic              flush,
  output logic              m_ren,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  generate
    if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : gBadParam
      $error("mem_port_arbiter: RD_LAT must be 1..4 and STARVE_MAX 1..15");
    end
  endgenerate

  logic   fEligible;
  logic   boost;
  logic   popValid;
  reqId_t popId;

  assign fEligible = f_req && !flush;

`ifdef MEM_ARB_FETCH_STARVE_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arbState_t  stateReg, stateNext;
  logic [3:0] starveCnt, starveCntNext;

  always_comb begin
    starveCntNext = starveCnt;
    stateNext     = stateReg;
    if (f_gnt || flush) begin
      starveCntNext = '0;
    end else if (f_req && starveCnt != 4'hF) begin
      starveCntNext = starveCnt + 4'd1;
    end
    case (stateReg)
      NORMAL:      if (starveCntNext == STARVE_LIM) stateNext = FETCH_BOOST;
      FETCH_BOOST: if (f_gnt || flush) stateNext = NORMAL;
      default:     stateNext = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
      stateReg  <= NORMAL;
    end else begin
      starveCnt <= starveCntNext;
      stateReg  <= stateNext;
    end
  end

  assign boost = (stateReg == FETCH_BOOST);
`else
  assign boost = 1'b0;
`endif

  always_comb begin
    s_gnt = 1'b0;
    l_gnt = 1'b0;
    f_gnt = 1'b0;
    if (!rst) begin
      if (boost && fEligible) f_gnt = 1'b1;
      else if (s_req)         s_gnt = 1'b1;
      else if (l_req)         l_gnt = 1'b1;
      else if (fEligible)     f_gnt = 1'b1;
    end
  end

  always_comb begin
    m_ren   = l_gnt || f_gnt;
    m_wen   = s_gnt;
    m_addr  = '0;
    m_wdata = '0;
    if (s_gnt) begin
      m_addr  = s_addr;
      m_wdata = s_data;
    end else if (l_gnt) begin
      m_addr = l_addr;
    end else if (f_gnt) begin
      m_addr = f_addr;
    end
  end

  mem_arb_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) uTagPipe (
    .clk       (clk),
    .rst       (rst),
    .push_valid(l_gnt || f_gnt),
    .push_id   (l_gnt ? LOAD : FETCH),
    .kill_fetch(flush),
    .pop_valid (popValid),
    .pop_id    (popId)
  );

  assign f_rvalid = !rst && popValid && (popId == FETCH);
  assign l_rvalid = !rst && popValid && (popId == LOAD);
  assign f_rdata  = f_rvalid ? m_rdata : '0;
  assign l_rdata  = l_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-accurate memory model and a response scoreboard.
module tb_mem_port_arbiter;

  localparam int RD_LAT     = 2;
  localparam int STARVE_MAX = 4;
`ifdef MEM_ARB_FETCH_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [15:0] data;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, l_req = 1'b0, s_req = 1'b0, flush = 1'b0;
  logic [15:0] f_addr = '0, l_addr = '0, s_addr = '0, s_data = '0;
  logic        f_gnt, l_gnt, s_gnt, f_rvalid, l_rvalid, m_ren, m_wen;
  logic [15:0] f_rdata, l_rdata, m_addr, m_wdata, m_rdata;

  int  total = 0;
  int  bad   = 0;
  int  cycNum = 0;
  expT fQ[$];
  expT lQ[$];
  expT fE, lE;

  logic [15:0] mem [256];
  logic [15:0] rdPipe [RD_LAT];

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .RD_LAT(RD_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_data(s_data), .s_gnt(s_gnt),
    .flush(flush),
    .m_ren(m_ren), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory model: contents start as addr ^ 16'hA5A5; idle read slots return 16'hDEAD.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    for (int i = 0; i < RD_LAT; i++) rdPipe[i] = 16'hDEAD;
  end

  always @(posedge clk) begin
    cycNum <= cycNum + 1;
    rdPipe[0] <= m_ren ? mem[m_addr[7:0]] : 16'hDEAD;
    for (int k = 1; k < RD_LAT; k++) rdPipe[k] <= rdPipe[k-1];
    if (m_wen) mem[m_addr[7:0]] <= m_wdata;
  end

  assign m_rdata = rdPipe[RD_LAT-1];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycNum);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", nm, act, cycNum);
    end
  endtask

  // Monitor: every response is matched against the scoreboard, including its arrival cycle.
  always @(negedge clk) begin
    if (f_rvalid) begin
      if (fQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL f_rvalid_unexpected: got rdata %0h expected no response (cycle %0d)", f_rdata, cycNum);
      end else begin
        fE = fQ.pop_front();
        chk("f_rdata", 128'(f_rdata), 128'(fE.data));
        chk("f_due", 128'(cycNum), 128'(fE.due));
      end
    end else begin
      chk("f_rdata_idle", 128'(f_rdata), 128'(0));
    end
    if (l_rvalid) begin
      if (lQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL l_rvalid_unexpected: got rdata %0h expected no response (cycle %0d)", l_rdata, cycNum);
      end else begin
        lE = lQ.pop_front();
        chk("l_rdata", 128'(l_rdata), 128'(lE.data));
        chk("l_due", 128'(cycNum), 128'(lE.due));
      end
    end else begin
      chk("l_rdata_idle", 128'(l_rdata), 128'(0));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic [15:0] fa, input logic l, input logic [15:0] la,
                       input logic s, input logic [15:0] sa, input logic [15:0] sd, input logic fl);
    f_req = f; f_addr = fa; l_req = l; l_addr = la;
    s_req = s; s_addr = sa; s_data = sd; flush = fl;
  endtask

  // Packed as {s_gnt, l_gnt, f_gnt, m_wen, m_ren}.
  task automatic expGnt(input string nm, input logic [4:0] exp);
    chk(nm, 128'({s_gnt, l_gnt, f_gnt, m_wen, m_ren}), 128'(exp));
  endtask

  task automatic pushF(input logic [15:0] d);
    fQ.push_back('{cycNum + RD_LAT, d});
  endtask

  task automatic pushL(input logic [15:0] d);
    lQ.push_back('{cycNum + RD_LAT, d});
  endtask

  function automatic logic [127:0] allOuts();
    return 128'({f_gnt, l_gnt, s_gnt, f_rvalid, l_rvalid, f_rdata, l_rdata,
                 m_ren, m_wen, m_addr, m_wdata});
  endfunction

  initial begin
    // Reset with every requester active: all outputs must stay at zero.
    rst = 1'b1;
    drive(1, 16'h0010, 1, 16'h0040, 1, 16'h0020, 16'hBEEF, 0);
    step(); step();
    #2 chk("rst_outputs", allOuts(), 128'(0));

    // Fetch alone, first cycle after reset release.
    step(); rst = 1'b0;
    drive(1, 16'h0010, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    #2 expGnt("fetch_alone", 5'b00101);
    chk("fetch_alone_addr", 128'(m_addr), 128'(16'h0010));
    pushF(16'hA5B5);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 expGnt("idle", 5'b00000);
    step(); step();

    // All three requesting: store, then load, then fetch.
    step(); drive(1, 16'h0050, 1, 16'h0040, 1, 16'h0020, 16'hBEEF, 0);
    #2 expGnt("prio_store", 5'b10010);
    chk("prio_store_addr", 128'(m_addr), 128'(16'h0020));
    chk("prio_store_wdata", 128'(m_wdata), 128'(16'hBEEF));
    step(); drive(1, 16'h0050, 1, 16'h0040, 0, 16'h0, 16'h0, 0);
    #2 expGnt("prio_load", 5'b01001);
    chk("prio_load_addr", 128'(m_addr), 128'(16'h0040));
    pushL(16'hA5E5);
    step(); drive(1, 16'h0050, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    #2 expGnt("prio_fetch", 5'b00101);
    chk("prio_fetch_addr", 128'(m_addr), 128'(16'h0050));
    pushF(16'hA5F5);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Store then load of the same address returns the stored value.
    step(); drive(0, 16'h0, 0, 16'h0, 1, 16'h0030, 16'h1234, 0);
    #2 expGnt("st_0030", 5'b10010);
    step(); drive(0, 16'h0, 1, 16'h0030, 0, 16'h0, 16'h0, 0);
    #2 expGnt("ld_0030", 5'b01001);
    pushL(16'h1234);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Flush kills the in-flight fetch but not a load granted in the flush cycle.
    step(); drive(1, 16'h0060, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    #2 expGnt("flush_fetch_gnt", 5'b00101);
    step(); drive(1, 16'h0060, 1, 16'h0070, 0, 16'h0, 16'h0, 1);
    #2 expGnt("flush_load_gnt", 5'b01001);
    pushL(16'hA5D5);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 chk("flush_no_frvalid", 128'(f_rvalid), 128'(0));
    step(); drive(1, 16'h0060, 0, 16'h0, 0, 16'h0, 16'h0, 1);
    #2 expGnt("flush_blocks_fetch", 5'b00000);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Load and fetch held together: the boost build grants fetch in cycle STARVE_MAX.
    for (int i = 0; i < 8; i++) begin
      step(); drive(1, 16'h0090, 1, 16'h0080, 0, 16'h0, 16'h0, 0);
      #2;
      if (STARVE_ON && i == STARVE_MAX) begin
        expGnt("starve_boost", 5'b00101);
        pushF(16'hA535);
      end else begin
        expGnt("starve_load", 5'b01001);
        pushL(16'hA525);
      end
    end
    step(); drive(1, 16'h0090, 0, 16'h0, 0, 16'h0, 16'h0, 0);
    #2 expGnt("starve_release", 5'b00101);
    pushF(16'hA535);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    // Reset one cycle after a load grant drops the load's response.
    step(); drive(0, 16'h0, 1, 16'h00A0, 0, 16'h0, 16'h0, 0);
    #2 expGnt("pre_rst_load", 5'b01001);
    step(); rst = 1'b1;
    drive(1, 16'h0010, 1, 16'h0040, 1, 16'h0020, 16'h5555, 0);
    #2 chk("rst2_outputs", allOuts(), 128'(0));
    step(); rst = 1'b0;
    drive(0, 16'h0, 1, 16'h0020, 0, 16'h0, 16'h0, 0);
    #2 chk("rst_no_lrvalid", 128'(l_rvalid), 128'(0));
    expGnt("post_rst_load", 5'b01001);
    pushL(16'hBEEF);
    step(); drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step();

    chk("fq_drained", 128'(fQ.size()), 128'(0));
    chk("lq_drained", 128'(lQ.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
